mult_div_unit: RTL and testbench



---
 rtl/mult_div_pkg.sv | 10 +
 rtl/div_restoring_core.sv | 16 +
 rtl/mult_div_unit.sv | 115 +++++++++++
 tb/tb_mult_div_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared constants and types for the multiply/divide unit
package mult_div_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_W = 6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;
  typedef enum logic {OP_MULT, OP_DIV} op_e;
endpackage

// File: rtl/div_restoring_core.sv
// div_restoring_core: one restoring-division step on unsigned magnitudes
module div_restoring_core #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);
  logic [W:0] trial, diff;
  assign trial = {rem, quo[W-1]};
  assign diff = trial - {1'b0, divisor};
  assign rem_next = diff[W] ? trial[W-1:0] : diff[W-1:0];
  assign quo_next = {quo[W-2:0], ~diff[W]};
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle Booth multiply / restoring divide producing HI/LO.
// MULTDIV_UNSIGNED_EN adds signed_op for multu/divu.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_mult,
  input  logic                  start_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic                  signed_op,
`endif
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  op_e op;
  logic sgn, sgn_in, a_neg, b_neg, a_neg_in;
  logic [W-1:0] a_lat, b_lat, rem, quo, rem_nx, quo_nx, div_mag, a_mag_in;
  logic [W:0] m_ext, add_res;
  logic [2*W+1:0] acc, acc_nx;
`ifdef MULTDIV_UNSIGNED_EN
  assign sgn_in = signed_op;
`else
  assign sgn_in = 1'b1;
`endif
  assign busy = state != IDLE;
  assign a_neg_in = sgn_in & op_a[W-1];
  assign a_mag_in = a_neg_in ? -op_a : op_a;
  assign a_neg = sgn & a_lat[W-1];
  assign b_neg = sgn & b_lat[W-1];
  assign div_mag = b_neg ? -b_lat : b_lat;
  // Accumulator: A (W+1 bits, room for the most negative multiplicand) | Q | q-1
  assign m_ext = {a_neg, a_lat};
  always_comb begin
    add_res = acc[1:0] == 2'b01 ? acc[2*W+1:W+1] + m_ext :
              acc[1:0] == 2'b10 ? acc[2*W+1:W+1] - m_ext : acc[2*W+1:W+1];
    acc_nx = {add_res[W], add_res, acc[W:1]};
  end
  div_restoring_core #(.W(W)) u_div (
    .rem(rem), .quo(quo), .divisor(div_mag), .rem_next(rem_nx), .quo_next(quo_nx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op <= OP_MULT;
      sgn <= 1'b1;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      a_lat <= '0;
      b_lat <= '0;
      rem <= '0;
      quo <= '0;
      acc <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            a_lat <= op_a;
            b_lat <= op_b;
            sgn <= sgn_in;
            cnt <= '0;
          end
          if (start_mult) begin
            op <= OP_MULT;
            acc <= {{(W+1){1'b0}}, op_b, 1'b0};
            state <= MULT;
          end else if (start_div) begin
            op <= OP_DIV;
            rem <= '0;
            quo <= a_mag_in;
            div_zero <= op_b == '0;
            state <= op_b == '0 ? FINISH : DIV;
          end
        end
        MULT: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(W-1)) state <= FINISH;
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(W-1)) state <= FINISH;
        end
        default: begin
          state <= IDLE;
          done <= 1'b1;
          // Unsigned Booth sees the multiplier as signed; add back M*2^W when its MSB is set
          if (op == OP_MULT) begin
            hi <= acc[2*W:W+1] + ((!sgn && b_lat[W-1]) ? a_lat : '0);
            lo <= acc[W:1];
          end else if (!div_zero) begin
            hi <= a_neg ? -rem : rem;
            lo <= (a_neg ^ b_neg) ? -quo : quo;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench against an arithmetic reference model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1, start_mult = 1'b0, start_div = 1'b0, signed_op = 1'b1;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic exp_dz = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
`ifdef MULTDIV_UNSIGNED_EN
    .signed_op(signed_op),
`endif
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  task automatic model(input logic m, input logic d, input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (m) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (d) begin
      if (b == 0) exp_dz = 1'b1;
      else begin
        q = sa / sb;
        r = sa % sb;
        p = q;
        exp_lo = p[31:0];
        p = r;
        exp_hi = p[31:0];
        exp_dz = 1'b0;
      end
    end
  endtask

  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b, output int bc, output int lat);
    start_mult = m; start_div = d; op_a = a; op_b = b;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0; op_a = $urandom; op_b = $urandom;
    bc = 0; lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done, div_zero} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_zero}); end
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    reset = 1'b0;
  endtask

  task automatic test_mult_sign;
    int bc, lat;
    do_op(1'b1, 1'b0, 32'd7, -32'sd3, bc, lat);
    model(1'b1, 1'b0, 1'b1, 32'd7, -32'sd3);
    checks++; if (bc != 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
    checks++; if (lat != 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin failures++; $display("FAIL mult_sign got=%h exp=ffffffffffffffeb", {hi, lo}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_div_sign;
    int bc, lat;
    do_op(1'b0, 1'b1, -32'sd7, 32'd2, bc, lat);
    model(1'b0, 1'b1, 1'b1, -32'sd7, 32'd2);
    checks++; if (lat != 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
    checks++; if ({hi, lo, div_zero} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin failures++; $display("FAIL div_sign got=%h/%h/%b exp=ffffffff/fffffffd/0", hi, lo, div_zero); end
  endtask

  task automatic test_div_zero;
    int bc, lat;
    do_op(1'b0, 1'b1, 32'h451, 32'h20, bc, lat);
    checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin failures++; $display("FAIL dz_preload got=%h exp=0000001100000022", {hi, lo}); end
    do_op(1'b0, 1'b1, 32'd5, 32'd0, bc, lat);
    checks++; if (lat != 1 || bc != 1) begin failures++; $display("FAIL dz_latency got=%0d/%0d exp=1/1", lat, bc); end
    checks++; if ({div_zero, hi, lo} !== {1'b1, 32'h11, 32'h22}) begin failures++; $display("FAIL dz_result got=%b/%h/%h exp=1/11/22", div_zero, hi, lo); end
    do_op(1'b1, 1'b0, 32'd2, 32'd3, bc, lat);
    checks++; if ({div_zero, lo} !== {1'b1, 32'd6}) begin failures++; $display("FAIL mult_keeps_dz got=%b/%h exp=1/6", div_zero, lo); end
    do_op(1'b0, 1'b1, 32'd9, 32'd4, bc, lat);
    checks++; if ({div_zero, hi, lo} !== {1'b0, 32'd1, 32'd2}) begin failures++; $display("FAIL div_clears_dz got=%b/%h/%h exp=0/1/2", div_zero, hi, lo); end
    exp_dz = 1'b0; exp_hi = 32'd1; exp_lo = 32'd2;
  endtask

  task automatic test_overflow;
    int bc, lat;
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, bc, lat);
    checks++; if ({hi, lo} !== {32'h0, 32'h80000000}) begin failures++; $display("FAIL div_overflow got=%h exp=0000000080000000", {hi, lo}); end
    do_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, bc, lat);
    checks++; if ({hi, lo} !== {32'h0, 32'h80000000}) begin failures++; $display("FAIL mult_large got=%h exp=0000000080000000", {hi, lo}); end
    do_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, bc, lat);
    checks++; if ({hi, lo} !== 64'h40000000_00000000) begin failures++; $display("FAIL mult_minmin got=%h exp=4000000000000000", {hi, lo}); end
    exp_hi = 32'h40000000; exp_lo = 32'h0;
  endtask

  task automatic test_reset_mid;
    int bc, lat;
    start_mult = 1'b1; op_a = 32'd1000; op_b = 32'd77;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({busy, done, hi, lo} !== 66'd0) begin failures++; $display("FAIL reset_mid got=%b/%b/%h/%h exp=0/0/0/0", busy, done, hi, lo); end
    do_op(1'b1, 1'b0, 32'd3, 32'd4, bc, lat);
    checks++; if ({hi, lo, lat} !== {32'd0, 32'd12, 32'd33}) begin failures++; $display("FAIL after_reset_mult got=%h/%h lat=%0d exp=0/c lat=33", hi, lo, lat); end
    exp_hi = 32'd0; exp_lo = 32'd12; exp_dz = 1'b0;
  endtask

  task automatic test_busy_ignore;
    int n;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    start_mult = 1'b1; start_div = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    model(1'b1, 1'b0, 1'b1, a, b);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      start_mult = $urandom_range(0, 1); start_div = 1'b1; op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      n++;
    end
    start_mult = 1'b0; start_div = 1'b0;
    checks++; if (n != 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", n); end
    checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin failures++; $display("FAIL ignore_result got=%h exp=%h", {hi, lo}, {exp_hi, exp_lo}); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL finish_start_ignored got=%b exp=0", busy); end
  endtask

  task automatic test_random;
    int bc, lat;
    logic m;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(0, 1);
      a = (i % 3 == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      b = (i % 3 == 1) ? 32'($signed($urandom_range(0, 20)) - 10) : $urandom;
      if (i == 7) b = 32'd0;
      do_op(m, ~m, a, b, bc, lat);
      model(m, ~m, 1'b1, a, b);
      checks++; if ({hi, lo, div_zero} !== {exp_hi, exp_lo, exp_dz} || lat != ((!m && b == 0) ? 1 : 33)) begin
        failures++; $display("FAIL random_%0d m=%b a=%h b=%h got=%h/%h/%b lat=%0d exp=%h/%h/%b", i, m, a, b, hi, lo, div_zero, lat, exp_hi, exp_lo, exp_dz);
      end
    end
  endtask

`ifdef MULTDIV_UNSIGNED_EN
  task automatic test_unsigned;
    int bc, lat;
    signed_op = 1'b0;
    do_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'd2, bc, lat);
    checks++; if ({hi, lo} !== {32'd1, 32'hFFFFFFFE}) begin failures++; $display("FAIL multu got=%h exp=00000001fffffffe", {hi, lo}); end
    do_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, bc, lat);
    checks++; if ({hi, lo} !== {32'd1, 32'h7FFFFFFF}) begin failures++; $display("FAIL divu got=%h exp=000000017fffffff", {hi, lo}); end
    do_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, lat);
    checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin failures++; $display("FAIL multu_max got=%h exp=fffffffe00000001", {hi, lo}); end
    signed_op = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_mult_sign;
    test_div_sign;
    test_div_zero;
    test_overflow;
    test_reset_mid;
    test_busy_ignore;
    test_random;
`ifdef MULTDIV_UNSIGNED_EN
    test_unsigned;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
